pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, is the width of every PC, immediate and target bus.
REQ-002 Parameter RAS_DEPTH, default 4, is the number of return-address stack entries; legal values are 2 to 16.
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded at reset.
REQ-004 Parameter PC_INC, default 1, is the sequential increment (1 = word-addressed, 4 = byte-addressed).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 branch_taken  in  1  take the PC-relative branch.
REQ-009 sign_imm  in  WIDTH  sign-extended branch offset.
REQ-010 jump  in  1  absolute jump to jump_target.
REQ-011 call  in  1  jump to jump_target and push the return address.
REQ-012 ret  in  1  pop the return address into the PC.
REQ-013 jump_target  in  WIDTH  absolute target for jump and call.
REQ-014 pc  out  WIDTH  current PC (registered).
REQ-015 pc_plus1  out  WIDTH  pc + PC_INC (combinational).
REQ-016 pc_branch  out  WIDTH  pc_plus1 + sign_imm (combinational).
REQ-017 ras_empty  out  1  stack count is 0.
REQ-018 ras_full  out  1  stack count equals RAS_DEPTH.
REQ-019 ras_err  out  1  sticky error flag for overflow or underflow.

Function
REQ-020 pc_plus1 and pc_branch shall be computed modulo 2^WIDTH, with wrap-around and no carry-out.
REQ-021 The next PC shall be selected in strict priority order:
- stall: hold pc;
- ret: take the stack top;
- call or jump: take jump_target;
- branch_taken: take pc_branch;
- otherwise: take pc_plus1.
REQ-022 The PC update latency shall be one cycle: the selected value appears on pc after the next rising edge.
REQ-023 The stack shall be a circular buffer with a top pointer and a count from 0 to RAS_DEPTH.
REQ-024 A call that is not stalled, with ret low, shall push pc_plus1 and increment the count.
REQ-025 A call when the stack is full shall overwrite the oldest entry, leave the count at RAS_DEPTH, and set ras_err.
REQ-026 A ret that is not stalled, with the count above 0, shall load the top entry into pc and decrement the count.
REQ-027 A ret on an empty stack shall load pc_plus1 into pc, leave the count at 0, and set ras_err.
REQ-028 When call and ret are asserted together (not stalled), pc shall take the current top entry.
REQ-029 In that same case the top entry shall be replaced by pc_plus1, the count shall not change, and no error is raised.
REQ-030 When call and ret are asserted together on an empty stack, pc shall take pc_plus1, one entry (pc_plus1) shall be pushed, and ras_err shall be set.
REQ-031 When stall is high, the call, ret, jump and branch inputs shall be ignored, with no stack change and no error update.
REQ-032 Once set, ras_err shall stay set until reset.
REQ-033 When jump and branch_taken are asserted together, jump shall win.
REQ-034 ras_empty and ras_full shall be decoded combinationally from the registered count.

Reset
REQ-035 Asserting reset shall immediately, without waiting for clk, set pc to RESET_PC, the count to 0 and ras_err to 0; ras_empty then reads 1 and ras_full 0.
REQ-036 Stack entry contents are don't-care after reset and need not be cleared.
REQ-037 Reset asserted mid-operation, including during a stall or a call/ret, shall abort that update with no partial stack change.
REQ-038 The first edge after reset deasserts shall apply normal next-PC selection.

Verification
REQ-039 Sequential run: reset, RESET_PC=0, PC_INC=1, 3 edges -> pc = 3, pc_plus1 = 4.
REQ-040 Branch: pc=0x10, sign_imm=0xFFFFFFFE, branch_taken=1 -> pc_branch = 0x0F, and pc = 0x0F after the edge.
REQ-041 Wrap: pc=0xFFFFFFFF, no control inputs -> pc = 0x00000000.
REQ-042 Call/return nesting:
- call at pc=0x20 to 0x100 -> pc = 0x100;
- call at pc=0x100 to 0x200 -> pc = 0x200;
- ret, then ret -> pc = 0x101, then pc = 0x21; ras_empty = 1 and ras_err = 0.
REQ-043 Overflow/underflow:
- RAS_DEPTH+1 calls -> ras_full = 1 and ras_err = 1; RAS_DEPTH rets return the newest RAS_DEPTH addresses in reverse order;
- a further ret -> pc = pc_plus1.
REQ-044 Stall and reset:
- stall=1 with call=1 -> pc, count and ras_err unchanged;
- reset asserted between edges -> pc = RESET_PC immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control and PC bus between an instruction-fetch front end and the PC sequencer.
// The master drives the next-PC controls; the slave (the sequencer) returns the PC
// and the return-address-stack status.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] sign_imm;
    logic             jump;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] pc_branch;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    modport master (
        output stall, branch_taken, sign_imm, jump, call, ret, jump_target,
        input  pc, pc_plus1, pc_branch, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, branch_taken, sign_imm, jump, call, ret, jump_target,
        output pc, pc_plus1, pc_branch, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a circular return-address stack.
// Next-PC priority: stall > ret > call/jump > branch > sequential.
// A full stack overwrites its oldest entry; overflow and underflow set a sticky error.
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               PC_INC    = 1
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] INC      = WIDTH'(PC_INC);
    localparam logic [PW-1:0]    TOP_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] pc_branch;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    // Adders wrap naturally at WIDTH bits; the offset is already sign-extended.
    assign pc_plus1  = pc_q + INC;
    assign pc_branch = pc_plus1 + bus.sign_imm;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign top_inc = (top_q == TOP_LAST) ? '0 : top_q + 1'b1;
    assign top_dec = (top_q == '0) ? TOP_LAST : top_q - 1'b1;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);

    // Next-state selection for PC, stack pointer, count and error flag.
    always_comb begin
        pc_d   = pc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        if (!bus.stall) begin
            if (bus.ret) begin
                if (empty) begin
                    // Underflow: fall through sequentially; a simultaneous call still pushes.
                    pc_d  = pc_plus1;
                    err_d = 1'b1;
                    if (bus.call) begin
                        wr_en  = 1'b1;
                        wr_idx = top_inc;
                        top_d  = top_inc;
                        cnt_d  = CW'(1);
                    end
                end else begin
                    pc_d = ras_q[top_q];
                    if (bus.call) begin
                        // Return and call in one cycle: swap the top entry in place.
                        wr_en  = 1'b1;
                        wr_idx = top_q;
                    end else begin
                        top_d = top_dec;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end else if (bus.call) begin
                pc_d   = bus.jump_target;
                wr_en  = 1'b1;
                wr_idx = top_inc;
                top_d  = top_inc;
                // When full, the advanced pointer lands on the oldest entry and overwrites it.
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (bus.jump) begin
                pc_d = bus.jump_target;
            end else if (bus.branch_taken) begin
                pc_d = pc_branch;
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack storage is not cleared; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            ras_q[wr_idx] <= pc_plus1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus1  = pc_plus1;
    assign bus.pc_branch = pc_branch;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based reference model and
// per-cycle comparison, plus literal expectations for the key scenarios.
module tb_pc_sequencer;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH(W), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0), .PC_INC(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: PC, stack as a queue (newest at the back), error flag.
    logic [W-1:0] m_pc  = '0;
    logic         m_err = 1'b0;
    logic [W-1:0] m_stk [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge or reset assertion.
    initial begin
        forever begin
            logic [W-1:0] p1;
            logic [W-1:0] nxt;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_pc  = '0;
                m_err = 1'b0;
                m_stk.delete();
            end else if (!bus.stall) begin
                p1  = m_pc + 1;
                nxt = p1;
                if (bus.ret) begin
                    if (m_stk.size() > 0) begin
                        nxt = m_stk[$];
                        if (bus.call) m_stk[m_stk.size()-1] = p1;
                        else void'(m_stk.pop_back());
                    end else begin
                        nxt   = p1;
                        m_err = 1'b1;
                        if (bus.call) m_stk.push_back(p1);
                    end
                end else if (bus.call) begin
                    nxt = bus.jump_target;
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                    m_stk.push_back(p1);
                end else if (bus.jump) begin
                    nxt = bus.jump_target;
                end else if (bus.branch_taken) begin
                    nxt = p1 + bus.sign_imm;
                end
                m_pc = nxt;
            end
        end
    end

    // Per-cycle comparison against the model, just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("pc",        bus.pc,        m_pc);
            chk("pc_plus1",  bus.pc_plus1,  m_pc + 1);
            chk("pc_branch", bus.pc_branch, m_pc + 1 + bus.sign_imm);
            chk("ras_empty", {31'b0, bus.ras_empty}, {31'b0, m_stk.size() == 0});
            chk("ras_full",  {31'b0, bus.ras_full},  {31'b0, m_stk.size() == DEPTH});
            chk("ras_err",   {31'b0, bus.ras_err},   {31'b0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ctl(input logic st, input logic cl, input logic rt, input logic jp,
                       input logic br, input logic [W-1:0] tgt, input logic [W-1:0] imm);
        bus.stall        = st;
        bus.call         = cl;
        bus.ret          = rt;
        bus.jump         = jp;
        bus.branch_taken = br;
        bus.jump_target  = tgt;
        bus.sign_imm     = imm;
    endtask

    initial begin
        reset = 1'b1;
        ctl(0, 0, 0, 0, 0, '0, '0);
        tick();
        chk("rst_pc",    bus.pc, 32'h0);
        chk("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("rst_full",  {31'b0, bus.ras_full},  32'h0);
        chk("rst_err",   {31'b0, bus.ras_err},   32'h0);
        reset = 1'b0;

        // Sequential run
        repeat (3) tick();
        chk("seq_pc",  bus.pc,       32'h3);
        chk("seq_pc1", bus.pc_plus1, 32'h4);

        // Negative branch from 0x10
        ctl(0, 0, 0, 1, 0, 32'h10, '0);
        tick();
        chk("jmp_pc", bus.pc, 32'h10);
        ctl(0, 0, 0, 0, 1, '0, 32'hFFFF_FFFE);
        #1;
        chk("br_target", bus.pc_branch, 32'h0F);
        tick();
        chk("br_pc", bus.pc, 32'h0F);

        // Jump beats branch
        ctl(0, 0, 0, 1, 1, 32'h40, 32'h5);
        tick();
        chk("jmp_over_br", bus.pc, 32'h40);

        // Wrap-around
        ctl(0, 0, 0, 1, 0, 32'hFFFF_FFFF, '0);
        tick();
        ctl(0, 0, 0, 0, 0, '0, '0);
        #1;
        chk("wrap_pc1", bus.pc_plus1, 32'h0);
        tick();
        chk("wrap_pc", bus.pc, 32'h0);

        // Nested call/return
        ctl(0, 0, 0, 1, 0, 32'h20, '0);
        tick();
        ctl(0, 1, 0, 0, 0, 32'h100, '0);
        tick();
        chk("call1", bus.pc, 32'h100);
        ctl(0, 1, 0, 0, 0, 32'h200, '0);
        tick();
        chk("call2", bus.pc, 32'h200);
        ctl(0, 0, 1, 0, 0, '0, '0);
        tick();
        chk("ret1", bus.pc, 32'h101);
        tick();
        chk("ret2", bus.pc, 32'h21);
        ctl(0, 0, 0, 0, 0, '0, '0);
        chk("nest_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("nest_err",   {31'b0, bus.ras_err},   32'h0);

        // Call and ret together on a non-empty stack
        ctl(0, 1, 0, 0, 0, 32'h300, '0);
        tick();
        ctl(0, 1, 1, 0, 0, 32'h777, '0);
        tick();
        chk("swap_pc", bus.pc, 32'h22);
        chk("swap_err", {31'b0, bus.ras_err}, 32'h0);
        ctl(0, 0, 1, 0, 0, '0, '0);
        tick();
        chk("swap_ret", bus.pc, 32'h301);
        chk("swap_empty", {31'b0, bus.ras_empty}, 32'h1);

        // Stalled call changes nothing
        ctl(1, 1, 0, 0, 0, 32'h500, '0);
        tick();
        chk("stall_pc",    bus.pc, 32'h301);
        chk("stall_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("stall_err",   {31'b0, bus.ras_err},   32'h0);

        // Overflow: DEPTH+1 calls
        for (int i = 0; i <= DEPTH; i++) begin
            ctl(0, 1, 0, 0, 0, 32'h1000 + 32'(i) * 32'h10, '0);
            tick();
        end
        chk("ovf_full", {31'b0, bus.ras_full}, 32'h1);
        chk("ovf_err",  {31'b0, bus.ras_err},  32'h1);
        ctl(0, 0, 1, 0, 0, '0, '0);
        tick(); chk("ovf_ret1", bus.pc, 32'h1031);
        tick(); chk("ovf_ret2", bus.pc, 32'h1021);
        tick(); chk("ovf_ret3", bus.pc, 32'h1011);
        tick(); chk("ovf_ret4", bus.pc, 32'h1001);
        tick(); chk("udf_pc", bus.pc, 32'h1002);
        chk("udf_err", {31'b0, bus.ras_err}, 32'h1);

        // Call and ret together on an empty stack
        ctl(0, 1, 1, 0, 0, 32'h7777, '0);
        tick();
        chk("cr_empty_pc", bus.pc, 32'h1003);
        chk("cr_empty_nonempty", {31'b0, bus.ras_empty}, 32'h0);
        ctl(0, 0, 1, 0, 0, '0, '0);
        tick();
        chk("cr_empty_ret", bus.pc, 32'h1003);

        // Asynchronous reset between edges during a call
        ctl(0, 1, 0, 0, 0, 32'h900, '0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc",    bus.pc, 32'h0);
        chk("async_empty", {31'b0, bus.ras_empty}, 32'h1);
        chk("async_err",   {31'b0, bus.ras_err},   32'h0);
        tick();
        reset = 1'b0;
        ctl(0, 0, 0, 0, 0, '0, '0);
        tick();
        chk("post_rst_pc", bus.pc, 32'h1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
